// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives datapath enables, mux selects and the memory handshake.
module mips_multicycle_ctrl (
    input  logic        clock,
    input  logic        resetN,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        memAck,
    input  logic        exitReq,
    output logic        pcWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic        memReq,
    output logic        memWe,
    output logic        memAddrSel,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [2:0]  aluOp,
    output logic [1:0]  pcSrc,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic        syscall,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instCount
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state, nextState;
    logic   retire, illegalHalt, illegalQ;

    logic isR, isJ, isJal, isJr, isNop, isSys, isRalu;
    logic isBeq, isBne, isAddi, isOri, isLw, isSw, toExec;

    function automatic logic [2:0] rAluOp(input logic [5:0] f);
        case (f)
            6'd34:   return ALU_SUB;
            6'd36:   return ALU_AND;
            6'd37:   return ALU_OR;
            6'd42:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    always_comb begin
        isR    = (opcode == 6'd0);
        isJ    = (opcode == 6'd2);
        isJal  = (opcode == 6'd3);
        isBeq  = (opcode == 6'd4);
        isBne  = (opcode == 6'd5);
        isAddi = (opcode == 6'd8);
        isOri  = (opcode == 6'd13);
        isLw   = (opcode == 6'd35);
        isSw   = (opcode == 6'd43);
        isJr   = isR && (funct == 6'd8);
        isNop  = isR && (funct == 6'd0);
        isSys  = isR && (funct == 6'd12);
        isRalu = isR && (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                         funct == 6'd37 || funct == 6'd42);
        toExec = isRalu || isSys || isBeq || isBne || isAddi || isOri || isLw || isSw;
    end

    // Everything is forced low while resetN is asserted, so an in-flight memory
    // request is withdrawn asynchronously rather than at the next clock.
    always_comb begin
        pcWrite     = 1'b0;
        irWrite     = 1'b0;
        regWrite    = 1'b0;
        memReq      = 1'b0;
        memWe       = 1'b0;
        memAddrSel  = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'd0;
        aluOp       = ALU_AND;
        pcSrc       = 2'd0;
        regDst      = 2'd0;
        memToReg    = 2'd0;
        syscall     = 1'b0;
        halted      = 1'b0;
        nextState   = state;
        illegalHalt = 1'b0;
        retire      = 1'b0;
        if (resetN) begin
            case (state)
                FETCH: begin
                    memReq  = 1'b1;
                    aluSrcB = 2'd1;
                    aluOp   = ALU_ADD;
                    if (memAck) begin
                        pcWrite   = 1'b1;
                        irWrite   = 1'b1;
                        nextState = DECODE;
                    end
                end
                DECODE: begin
                    aluSrcB = 2'd3;
                    aluOp   = ALU_ADD;
                    if (isJ || isJal) begin
                        pcWrite   = 1'b1;
                        pcSrc     = 2'd2;
                        nextState = FETCH;
                        if (isJal) begin
                            regWrite = 1'b1;
                            regDst   = 2'd2;
                            memToReg = 2'd2;
                        end
                    end else if (isJr) begin
                        pcWrite   = 1'b1;
                        pcSrc     = 2'd3;
                        nextState = FETCH;
                    end else if (isNop) begin
                        nextState = FETCH;
                    end else if (toExec) begin
                        nextState = EXEC;
                    end else begin
                        nextState   = HALT;
                        illegalHalt = 1'b1;
                    end
                end
                EXEC: begin
                    aluSrcA = 1'b1;
                    if (isSys) begin
                        syscall   = 1'b1;
                        nextState = exitReq ? HALT : FETCH;
                    end else if (isRalu) begin
                        aluOp     = rAluOp(funct);
                        nextState = WB;
                    end else if (isAddi || isLw || isSw) begin
                        aluSrcB   = 2'd2;
                        aluOp     = ALU_ADD;
                        nextState = (isAddi) ? WB : MEM;
                    end else if (isOri) begin
                        aluSrcB   = 2'd2;
                        aluOp     = ALU_OR;
                        nextState = WB;
                    end else if (isBeq || isBne) begin
                        aluOp     = ALU_SUB;
                        pcSrc     = 2'd1;
                        pcWrite   = isBeq ? zero : ~zero;
                        nextState = FETCH;
                    end else begin
                        nextState   = HALT;
                        illegalHalt = 1'b1;
                    end
                end
                MEM: begin
                    memReq     = 1'b1;
                    memAddrSel = 1'b1;
                    memWe      = isSw;
                    if (memAck) nextState = isSw ? FETCH : WB;
                end
                WB: begin
                    regWrite  = 1'b1;
                    regDst    = isRalu ? 2'd1 : 2'd0;
                    memToReg  = isLw ? 2'd1 : 2'd0;
                    nextState = FETCH;
                end
                default: begin
                    halted = 1'b1;
                end
            endcase
            // An instruction retires on its last cycle; a syscall exit counts, an illegal halt does not.
            retire = ((nextState == FETCH) && (state != FETCH)) ||
                     ((state == EXEC) && isSys && exitReq);
        end
    end

    assign illegal = illegalQ;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= FETCH;
            instCount <= 32'd0;
            illegalQ  <= 1'b0;
        end else begin
            state <= nextState;
            if (retire)      instCount <= instCount + 32'd1;
            if (illegalHalt) illegalQ  <= 1'b1;
        end
    end

endmodule
